// File: rtl/countdown_sequencer_pkg.sv
// Shared types and default timing constants for the countdown sequencer.
package countdown_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // 1 s decrement period and 20 ms debounce window at 50 MHz.
  localparam int DEF_TICK_DIV  = 50_000_000;
  localparam int DEF_DB_CYCLES = 1_000_000;

endpackage

// File: rtl/countdown_sequencer_button_conditioner.sv
// Raw push-button to one-cycle press pulse: 2-FF synchronizer, debounce
// filter, rising-edge detector. A glitch shorter than DB_CYCLES is dropped.
module button_conditioner
  import countdown_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] db_cnt;

  // Bring the asynchronous button into the clk domain.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level only after it has disagreed for DB_CYCLES cycles in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level  <= 1'b0;
      db_cnt <= '0;
    end else if (sync_q2 == level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      level  <= sync_q2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + CW'(1);
    end
  end

  // Registered one-cycle pulse on each accepted 0->1 transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      level_q <= level;
      pulse   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/countdown_sequencer.sv
// Control FSM for the seven-segment down-counter: conditions the load,
// start and pause buttons, loads the datapath from the switches and issues
// prescaled decrement strobes until the count reaches zero.
module countdown_sequencer
  import countdown_pkg::*;
#(
  parameter int N         = 6,
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_load,
  input  logic         btn_start,
  input  logic         btn_pause,
  input  logic [N-1:0] sw_value,
  input  logic [N-1:0] count_in,
  output logic         load,
  output logic [N-1:0] load_value,
  output logic         dec,
  output logic         done,
  output logic [2:0]   state_out
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        state;
  logic [PW-1:0] presc;
  logic          load_p;
  logic          start_p;
  logic          pause_p;
  logic          tick;

  button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_load_btn (
    .clk(clk), .rst(rst), .btn_raw(btn_load), .pulse(load_p)
  );

  button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_start_btn (
    .clk(clk), .rst(rst), .btn_raw(btn_start), .pulse(start_p)
  );

  button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_pause_btn (
    .clk(clk), .rst(rst), .btn_raw(btn_pause), .pulse(pause_p)
  );

  // The prescaler only advances in RUN, so its terminal count is the tick.
  assign tick      = (presc == PRESC_LAST);
  assign state_out = state;

  // Sequencer: load > pause > start > tick; all outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      presc      <= '0;
      load       <= 1'b0;
      load_value <= '0;
      dec        <= 1'b0;
      done       <= 1'b0;
    end else begin
      load <= 1'b0;
      dec  <= 1'b0;
      if (load_p) begin
        // Load reloads from every state and discards any same-cycle tick.
        load       <= 1'b1;
        load_value <= sw_value;
        done       <= 1'b0;
        state      <= S_READY;
      end else begin
        case (state)
          S_READY: begin
            if (start_p) begin
              presc <= '0;
              state <= S_RUN;
            end
          end
          S_RUN: begin
            if (pause_p) begin
              // Prescaler holds so the resumed period finishes where it left off.
              state <= S_PAUSE;
            end else if (tick) begin
              presc <= '0;
              if (count_in != '0) begin
                dec <= 1'b1;
              end
              if (count_in <= N'(1)) begin
                done  <= 1'b1;
                state <= S_DONE;
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
          S_PAUSE: begin
            if (start_p || pause_p) begin
              state <= S_RUN;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_sequencer.sv
// Self-checking bench: a behavioural model of the sequencer is compared
// against the DUT every cycle, and directed scenarios pin timing literally.
module tb_countdown_sequencer;

  localparam int N   = 6;
  localparam int TD  = 4;
  localparam int DB  = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         btn_load = 1'b0;
  logic         btn_start = 1'b0;
  logic         btn_pause = 1'b0;
  logic [N-1:0] sw_value = '0;
  logic [N-1:0] count_in;
  logic         load;
  logic [N-1:0] load_value;
  logic         dec;
  logic         done;
  logic [2:0]   state_out;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int dec_cnt = 0;
  int load_cnt = 0;
  int last_load_cyc = 0;
  int dec_cyc[$];

  countdown_sequencer #(.N(N), .TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst),
    .btn_load(btn_load), .btn_start(btn_start), .btn_pause(btn_pause),
    .sw_value(sw_value), .count_in(count_in),
    .load(load), .load_value(load_value), .dec(dec), .done(done),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stand-in: counter register fed by the DUT's strobes.
  always @(posedge clk or posedge rst) begin
    if (rst) count_in <= '0;
    else if (load) count_in <= load_value;
    else if (dec && count_in != '0) count_in <= count_in - 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Buttons: raw level delayed two cycles, accepted after DB equal-run
  // samples that disagree with the accepted level; a press is reported one
  // cycle after the accepted level rises.
  bit m_line[3][2];
  bit m_acc[3];
  bit m_acc_prev[3];
  int m_run[3];
  bit m_press[3];
  int m_state = 0;     // 0 idle, 1 ready, 2 run, 3 pause, 4 done
  int m_elapsed = 0;   // cycles into the current decrement period
  int m_count = 0;
  bit m_load = 0;
  int m_load_value = 0;
  bit m_dec = 0;
  bit m_done = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (m_acc[b]) begin
        m_line[b][0] = 0; m_line[b][1] = 0;
        m_acc[b] = 0; m_acc_prev[b] = 0; m_run[b] = 0; m_press[b] = 0;
      end
      m_state = 0; m_elapsed = 0; m_count = 0;
      m_load = 0; m_load_value = 0; m_dec = 0; m_done = 0;
    end else begin
      bit raw[3];
      raw[0] = btn_load; raw[1] = btn_start; raw[2] = btn_pause;
      // datapath reflects last cycle's strobes
      if (m_load) m_count = m_load_value;
      else if (m_dec && m_count > 0) m_count--;
      m_load = 0;
      m_dec = 0;
      if (m_press[0]) begin
        m_load = 1; m_load_value = int'(sw_value); m_state = 1;
      end else if (m_state == 1) begin
        if (m_press[1]) begin m_state = 2; m_elapsed = 0; end
      end else if (m_state == 2) begin
        if (m_press[2]) m_state = 3;
        else if (m_elapsed == TD - 1) begin
          m_elapsed = 0;
          m_dec = (m_count > 0);
          if (m_count <= 1) m_state = 4;
        end else m_elapsed++;
      end else if (m_state == 3) begin
        if (m_press[1] || m_press[2]) m_state = 2;
      end
      m_done = (m_state == 4);
      for (int b = 0; b < 3; b++) begin
        bit seen;
        seen = m_line[b][1];
        m_press[b] = m_acc[b] && !m_acc_prev[b];
        m_acc_prev[b] = m_acc[b];
        if (seen != m_acc[b]) begin
          m_run[b]++;
          if (m_run[b] == DB) begin m_acc[b] = seen; m_run[b] = 0; end
        end else m_run[b] = 0;
        m_line[b][1] = m_line[b][0];
        m_line[b][0] = raw[b];
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    check("load", 32'(load), 32'(m_load));
    check("load_value", 32'(load_value), 32'(m_load_value));
    check("dec", 32'(dec), 32'(m_dec));
    check("done", 32'(done), 32'(m_done));
    check("state_out", 32'(state_out), 32'(m_state));
    if (dec) begin dec_cnt++; dec_cyc.push_back(cyc); end
    if (load) begin load_cnt++; last_load_cyc = cyc; end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic press(input int which, input int len);
    if (which == 0) btn_load = 1'b1;
    if (which == 1) btn_start = 1'b1;
    if (which == 2) btn_pause = 1'b1;
    step(len);
    btn_load = 1'b0; btn_start = 1'b0; btn_pause = 1'b0;
  endtask

  int s;
  int base_dec;
  int base_load;

  initial begin
    // Reset
    step(3);
    check("rst_load", 32'(load), 0);
    check("rst_load_value", 32'(load_value), 0);
    check("rst_dec", 32'(dec), 0);
    check("rst_done", 32'(done), 0);
    check("rst_state", 32'(state_out), 0);
    rst = 1'b0;
    step(2);

    // Clean load of 5, then a full countdown
    sw_value = 6'd5;
    s = cyc;
    press(0, 5);
    step(12);
    check("load_pulses", 32'(load_cnt), 1);
    check("load_latency", 32'(last_load_cyc - s), 7);
    check("load_value_5", 32'(load_value), 5);
    check("ready_state", 32'(state_out), 1);

    press(1, 2);
    step(15);
    check("glitch_ignored", 32'(state_out), 1);

    base_dec = dec_cnt;
    s = cyc;
    press(1, 5);
    wait_until(s + 35);
    check("five_decs", 32'(dec_cnt - base_dec), 5);
    if (dec_cyc.size() >= 5) begin
      check("first_dec_at", 32'(dec_cyc[0] - s), 11);
      for (int i = 1; i < 5; i++) check("dec_spacing", 32'(dec_cyc[i] - dec_cyc[i-1]), 4);
    end else check("dec_log_size", 32'(dec_cyc.size()), 5);
    check("done_flag", 32'(done), 1);
    check("done_state", 32'(state_out), 4);
    check("count_zero", 32'(count_in), 0);
    step(40);
    check("no_sixth_dec", 32'(dec_cnt - base_dec), 5);

    // Pause after the 2nd dec, resume from the held prescaler
    press(0, 5);
    step(12);
    check("reload_ready", 32'(state_out), 1);
    dec_cyc.delete();
    base_dec = dec_cnt;
    s = cyc;
    press(1, 5);
    wait_until(s + 10);
    press(2, 5);
    wait_until(s + 19);
    check("paused_state", 32'(state_out), 3);
    check("decs_before_pause", 32'(dec_cnt - base_dec), 2);
    step(20);
    check("no_dec_paused", 32'(dec_cnt - base_dec), 2);
    check("still_paused", 32'(state_out), 3);
    s = cyc;
    press(1, 5);
    wait_until(s + 25);
    check("decs_after_resume", 32'(dec_cnt - base_dec), 5);
    if (dec_cyc.size() >= 3) check("resume_first_dec", 32'(dec_cyc[2] - s), 10);
    check("resume_done", 32'(state_out), 4);

    // Zero load: DONE at first tick without dec
    sw_value = 6'd0;
    press(0, 5);
    step(12);
    base_dec = dec_cnt;
    s = cyc;
    press(1, 5);
    wait_until(s + 16);
    check("zero_no_dec", 32'(dec_cnt - base_dec), 0);
    check("zero_done", 32'(state_out), 4);
    check("zero_done_flag", 32'(done), 1);

    // Load and pause in the same RUN cycle: load wins
    sw_value = 6'd9;
    press(0, 5);
    step(12);
    base_dec = dec_cnt;
    base_load = load_cnt;
    s = cyc;
    press(1, 5);
    wait_until(s + 9);
    btn_load = 1'b1; btn_pause = 1'b1;
    step(5);
    btn_load = 1'b0; btn_pause = 1'b0;
    wait_until(s + 20);
    check("load_wins_state", 32'(state_out), 1);
    check("load_wins_pulse", 32'(load_cnt - base_load), 1);
    check("load_wins_value", 32'(load_value), 9);
    check("load_wins_decs", 32'(dec_cnt - base_dec), 2);

    // Asynchronous reset mid-RUN
    s = cyc;
    press(1, 5);
    wait_until(s + 10);
    check("pre_rst_run", 32'(state_out), 2);
    #1 rst = 1'b1;
    #1;
    check("async_rst_state", 32'(state_out), 0);
    check("async_rst_dec", 32'(dec), 0);
    check("async_rst_load", 32'(load), 0);
    step(3);
    rst = 1'b0;
    step(5);
    check("post_rst_idle", 32'(state_out), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time bound");
    $fatal(1, "timeout");
  end

endmodule
